// File: rtl/asv_frame_enforcer.sv
// asv_frame_enforcer
// Checks the line/frame structure of an active-video beat stream and
// regenerates clean, registered frame markers plus one-cycle error pulses.
// A beat is a cycle with tvalid & tready. Every counter moves only on beats.
//
// Ports
//   aclk, areset            : clock; synchronous active-high reset
//   tvalid, tready          : stream handshake (observed only)
//   sof_in, eol_in          : start-of-frame / end-of-line markers from the source
//   cfg_width, cfg_height   : frame geometry, latched on the sof_in beat that starts a frame
//   sof_out, sol_out,
//   eol_out, eof_out        : registered frame markers
//   err_short, err_long,
//   err_early_sof, err_cfg  : registered one-cycle error pulses
//   frame_count             : completed frames, wraps at 16 bits
module asv_frame_enforcer #(
    parameter int W_MAX = 1920,
    parameter int H_MAX = 1080,
    parameter int B     = 0,
    parameter int PPC   = 1,
    localparam int WW   = $clog2(W_MAX) + 1,
    localparam int HW   = $clog2(H_MAX) + 1
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          tvalid,
    input  logic          tready,
    input  logic          sof_in,
    input  logic          eol_in,
    input  logic [WW-1:0] cfg_width,
    input  logic [HW-1:0] cfg_height,
    output logic          sof_out,
    output logic          sol_out,
    output logic          eol_out,
    output logic          eof_out,
    output logic          err_short,
    output logic          err_long,
    output logic          err_early_sof,
    output logic          err_cfg,
    output logic [15:0]   frame_count
);

    if (B > W_MAX || !(PPC == 1 || PPC == 2 || PPC == 4) || (W_MAX % PPC) != 0) begin : g_bad_params
        $error("asv_frame_enforcer: illegal parameters (B > W_MAX, PPC not 1/2/4, or W_MAX not a multiple of PPC)");
    end

    // One-hot state: bit positions and full codes.
    localparam int S_IDLE = 0;
    localparam int S_SOF  = 1;
    localparam int S_SOL  = 2;
    localparam int S_PIX  = 3;
    localparam int S_HBL  = 4;
    localparam int S_EOF  = 5;

    localparam logic [5:0] ST_IDLE = 6'b000001;
    localparam logic [5:0] ST_SOF  = 6'b000010;
    localparam logic [5:0] ST_SOL  = 6'b000100;
    localparam logic [5:0] ST_PIX  = 6'b001000;
    localparam logic [5:0] ST_HBL  = 6'b010000;
    localparam logic [5:0] ST_EOF  = 6'b100000;

    // Last blanking beat index; clamped so B == 0 never produces a negative constant.
    localparam logic [WW-1:0] BLANK_LAST = WW'(B > 0 ? B - 1 : 0);

    logic [5:0]    state_q, state_d;
    logic [WW-1:0] beat_count_q, beat_count_d;
    logic [HW-1:0] line_count_q, line_count_d;
    logic [WW-1:0] line_beats_q, line_beats_d;
    logic [HW-1:0] height_q, height_d;
    logic [15:0]   frame_count_q, frame_count_d;

    logic sof_out_q, sof_out_d;
    logic sol_out_q, sol_out_d;
    logic eol_out_q, eol_out_d;
    logic eof_out_q, eof_out_d;
    logic err_short_q, err_short_d;
    logic err_long_q, err_long_d;
    logic err_early_sof_q, err_early_sof_d;
    logic err_cfg_q, err_cfg_d;

    logic beat;
    logic last_beat;
    logic last_line;
    logic cfg_ok;
    logic in_frame;
    logic start_ok;
    logic early_sof;

    assign beat      = tvalid & tready;
    assign last_beat = (beat_count_q == line_beats_q - WW'(1));
    assign last_line = (line_count_q == height_q - HW'(1));
    assign cfg_ok    = (cfg_width != '0) && (cfg_width <= WW'(W_MAX)) &&
                       ((cfg_width % WW'(PPC)) == '0) &&
                       (cfg_height != '0) && (cfg_height <= HW'(H_MAX));
    assign in_frame  = state_q[S_SOF] | state_q[S_SOL] | state_q[S_PIX] | state_q[S_HBL];
    assign start_ok  = state_q[S_IDLE] & beat & sof_in & cfg_ok;
    // A sof_in beat inside a frame resynchronises to a fresh frame.
    assign early_sof = in_frame & beat & sof_in;

    // State and counter register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q         <= ST_IDLE;
            beat_count_q    <= '0;
            line_count_q    <= '0;
            line_beats_q    <= '0;
            height_q        <= '0;
            frame_count_q   <= '0;
            sof_out_q       <= 1'b0;
            sol_out_q       <= 1'b0;
            eol_out_q       <= 1'b0;
            eof_out_q       <= 1'b0;
            err_short_q     <= 1'b0;
            err_long_q      <= 1'b0;
            err_early_sof_q <= 1'b0;
            err_cfg_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            state_q         <= state_d;
            beat_count_q    <= beat_count_d;
            line_count_q    <= line_count_d;
            line_beats_q    <= line_beats_d;
            height_q        <= height_d;
            frame_count_q   <= frame_count_d;
            sof_out_q       <= sof_out_d;
            sol_out_q       <= sol_out_d;
            eol_out_q       <= eol_out_d;
            eof_out_q       <= eof_out_d;
            err_short_q     <= err_short_d;
            err_long_q      <= err_long_d;
            err_early_sof_q <= err_early_sof_d;
            err_cfg_q       <= err_cfg_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        // NOTE: hold-value defaults first, so no path through this block infers a latch.
        state_d       = state_q;
        beat_count_d  = beat_count_q;
        line_count_d  = line_count_q;
        line_beats_d  = line_beats_q;
        height_d      = height_q;
        frame_count_d = frame_count_q;

        unique case (1'b1)
            state_q[S_IDLE]: begin
                if (start_ok) begin
                    state_d = ST_SOF;
                end
            end
            state_q[S_SOF], state_q[S_SOL]: begin
                state_d = ST_PIX;
            end
            state_q[S_PIX]: begin
                if (beat) begin
                    if (last_beat) begin
                        line_count_d = line_count_q + HW'(1);
                        if (last_line) begin
                            state_d = ST_EOF;
                        end else if (B == 0) begin
                            state_d = ST_SOL;
                        end else begin
                            state_d = ST_HBL;
                        end
                    end else begin
                        beat_count_d = beat_count_q + WW'(1);
                    end
                end
            end
            state_q[S_HBL]: begin
                if (beat) begin
                    if (beat_count_q == BLANK_LAST) begin
                        state_d = ST_SOL;
                    end else begin
                        beat_count_d = beat_count_q + WW'(1);
                    end
                end
            end
            state_q[S_EOF]: begin
                state_d       = ST_IDLE;
                frame_count_d = frame_count_q + 16'd1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Frame start (normal or resync): latch geometry and restart counting.
        if (start_ok || early_sof) begin
            state_d      = ST_SOF;
            line_beats_d = cfg_width / WW'(PPC);
            height_d     = cfg_height;
            line_count_d = '0;
            beat_count_d = '0;
        end

        if (state_d != state_q) begin
            beat_count_d = '0;
        end
    end

    // Output logic: markers follow the next state, errors follow the current beat.
    always_comb begin
        sof_out_d       = state_d[S_SOF];
        sol_out_d       = state_d[S_SOF] | state_d[S_SOL];
        eol_out_d       = beat & eol_in;
        eof_out_d       = state_d[S_EOF];
        err_short_d     = state_q[S_PIX] & beat & eol_in & ~last_beat;
        err_long_d      = state_q[S_PIX] & beat & last_beat & ~eol_in;
        err_early_sof_d = early_sof;
        err_cfg_d       = state_q[S_IDLE] & beat & sof_in & ~cfg_ok;
    end

    assign sof_out       = sof_out_q;
    assign sol_out       = sol_out_q;
    assign eol_out       = eol_out_q;
    assign eof_out       = eof_out_q;
    assign err_short     = err_short_q;
    assign err_long      = err_long_q;
    assign err_early_sof = err_early_sof_q;
    assign err_cfg       = err_cfg_q;
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_asv_frame_enforcer.sv
// Self-checking bench for asv_frame_enforcer (W_MAX=16, H_MAX=8, B=2, PPC=2).
// The reference model tracks a frame as pixels received per line, lines
// finished and blank beats seen, and predicts every output after each edge.
module tb_asv_frame_enforcer;

    localparam int W_MAX = 16;
    localparam int H_MAX = 8;
    localparam int B     = 2;
    localparam int PPC   = 2;
    localparam int WW    = $clog2(W_MAX) + 1;
    localparam int HW    = $clog2(H_MAX) + 1;

    logic          aclk = 1'b0;
    logic          areset;
    logic          tvalid;
    logic          tready;
    logic          sof_in;
    logic          eol_in;
    logic [WW-1:0] cfg_width;
    logic [HW-1:0] cfg_height;
    logic          sof_out, sol_out, eol_out, eof_out;
    logic          err_short, err_long, err_early_sof, err_cfg;
    logic [15:0]   frame_count;

    int tests = 0;
    int fails = 0;

    always #5 aclk = ~aclk;

    asv_frame_enforcer #(.W_MAX(W_MAX), .H_MAX(H_MAX), .B(B), .PPC(PPC)) dut (
        .aclk(aclk), .areset(areset), .tvalid(tvalid), .tready(tready),
        .sof_in(sof_in), .eol_in(eol_in), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .sof_out(sof_out), .sol_out(sol_out), .eol_out(eol_out), .eof_out(eof_out),
        .err_short(err_short), .err_long(err_long), .err_early_sof(err_early_sof),
        .err_cfg(err_cfg), .frame_count(frame_count)
    );

    // ---------------- reference model ----------------
    typedef enum {MP_IDLE, MP_SOF, MP_SOL, MP_PIX, MP_BLANK, MP_EOF} mphase_t;

    mphase_t     m_ph = MP_IDLE;
    int          m_w, m_h;
    int          m_pix;     // pixels received in the current line
    int          m_line;    // lines finished in the current frame
    int          m_gap;     // blank beats seen after the current line
    logic [15:0] m_frames = '0;
    logic [23:0] exp_vec  = '0;

    function automatic logic [23:0] obs_vec();
        return {sof_out, sol_out, eol_out, eof_out,
                err_short, err_long, err_early_sof, err_cfg, frame_count};
    endfunction

    function automatic bit cfg_valid(int w, int h);
        return (w > 0) && (w <= W_MAX) && (w % PPC == 0) && (h > 0) && (h <= H_MAX);
    endfunction

    // True when the next pixel beat completes the current line.
    function automatic bit at_final_pixel();
        return (m_ph == MP_PIX) && (m_pix + PPC == m_w);
    endfunction

    task automatic start_frame();
        m_w    = int'(cfg_width);
        m_h    = int'(cfg_height);
        m_pix  = 0;
        m_line = 0;
        m_gap  = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit      beat;
        bit      e_s, e_l, e_e, e_c;
        mphase_t nxt;
        beat = tvalid && tready;
        e_s = 0; e_l = 0; e_e = 0; e_c = 0;
        if (areset) begin
            m_ph = MP_IDLE; m_pix = 0; m_line = 0; m_gap = 0; m_frames = '0;
            exp_vec = '0;
            return;
        end
        nxt = m_ph;
        case (m_ph)
            MP_IDLE: begin
                if (beat && sof_in) begin
                    if (cfg_valid(int'(cfg_width), int'(cfg_height))) begin
                        start_frame();
                        nxt = MP_SOF;
                    end else begin
                        e_c = 1;
                    end
                end
            end
            MP_SOF, MP_SOL: nxt = MP_PIX;
            MP_PIX: begin
                if (beat) begin
                    m_pix += PPC;
                    if (m_pix >= m_w) begin
                        e_l = !eol_in;
                        m_line++;
                        m_pix = 0;
                        m_gap = 0;
                        if (m_line == m_h) nxt = MP_EOF;
                        else if (B == 0)   nxt = MP_SOL;
                        else               nxt = MP_BLANK;
                    end else if (eol_in) begin
                        e_s = 1;
                    end
                end
            end
            MP_BLANK: begin
                if (beat) begin
                    m_gap++;
                    if (m_gap == B) nxt = MP_SOL;
                end
            end
            MP_EOF: begin
                m_frames = m_frames + 16'd1;
                nxt = MP_IDLE;
            end
            default: nxt = MP_IDLE;
        endcase
        if (beat && sof_in && (m_ph inside {MP_SOF, MP_SOL, MP_PIX, MP_BLANK})) begin
            e_e = 1;
            start_frame();
            nxt = MP_SOF;
        end
        m_ph = nxt;
        exp_vec = {m_ph == MP_SOF, (m_ph == MP_SOF) || (m_ph == MP_SOL), beat && eol_in,
                   m_ph == MP_EOF, e_s, e_l, e_e, e_c, m_frames};
    endtask

    task automatic tick();
        model_step();
        @(posedge aclk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        areset = 1; tvalid = 0; tready = 0; sof_in = 0; eol_in = 0;
        cfg_width = 5'd8; cfg_height = 4'd3;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++;
            if (obs_vec() !== 24'h0) begin
                fails++;
                $display("FAIL reset_outputs: got %h, expected %h", obs_vec(), 24'h0);
            end
        end
        areset = 0;
    endtask

    task automatic test_nominal();
        int sol_n = 0, eof_n = 0, eol_n = 0, err_n = 0;
        cfg_width = 5'd8; cfg_height = 4'd3; tvalid = 1; tready = 1;
        for (int c = 0; c < 200; c++) begin
            sof_in = (c == 0);
            eol_in = at_final_pixel();
            tick();
            tests++;
            if (obs_vec() !== exp_vec) begin
                fails++;
                $display("FAIL nominal_cycle%0d: got %h, expected %h", c, obs_vec(), exp_vec);
            end
            sol_n += int'(sol_out); eof_n += int'(eof_out); eol_n += int'(eol_out);
            err_n += int'(err_short) + int'(err_long) + int'(err_early_sof) + int'(err_cfg);
            if (m_ph == MP_IDLE) break;
        end
        sof_in = 0; eol_in = 0;
        tests++; if (sol_n != 3) begin fails++; $display("FAIL nominal_sol_count: got %0d, expected 3", sol_n); end
        tests++; if (eof_n != 1) begin fails++; $display("FAIL nominal_eof_count: got %0d, expected 1", eof_n); end
        tests++; if (eol_n != 3) begin fails++; $display("FAIL nominal_eol_count: got %0d, expected 3", eol_n); end
        tests++; if (err_n != 0) begin fails++; $display("FAIL nominal_errors: got %0d, expected 0", err_n); end
        tests++; if (frame_count !== 16'd1) begin fails++; $display("FAIL nominal_frame_count: got %0d, expected 1", frame_count); end
    endtask

    task automatic test_backpressure();
        int sol_n = 0, eof_n = 0, eol_n = 0, last_c = -1, eof_c = -2;
        bit left_idle = 0;
        cfg_width = 5'd8; cfg_height = 4'd3; tvalid = 1;
        for (int c = 0; c < 400; c++) begin
            tready = 1'($urandom_range(0, 1));
            sof_in = (m_ph == MP_IDLE);
            eol_in = at_final_pixel();
            if (at_final_pixel() && (m_line == m_h - 1) && tready) last_c = c;
            tick();
            tests++;
            if (obs_vec() !== exp_vec) begin
                fails++;
                $display("FAIL backpressure_cycle%0d: got %h, expected %h", c, obs_vec(), exp_vec);
            end
            sol_n += int'(sol_out); eof_n += int'(eof_out); eol_n += int'(eol_out);
            if (eof_out) eof_c = c;
            if (m_ph != MP_IDLE) left_idle = 1;
            else if (left_idle) break;
        end
        sof_in = 0; eol_in = 0; tready = 1;
        tests++; if (sol_n != 3) begin fails++; $display("FAIL bp_sol_count: got %0d, expected 3", sol_n); end
        tests++; if (eof_n != 1) begin fails++; $display("FAIL bp_eof_count: got %0d, expected 1", eof_n); end
        tests++; if (eol_n != 3) begin fails++; $display("FAIL bp_eol_count: got %0d, expected 3", eol_n); end
        tests++; if (eof_c != last_c) begin fails++; $display("FAIL bp_eof_timing: eof at cycle %0d, expected %0d", eof_c, last_c); end
        tests++; if (frame_count !== 16'd2) begin fails++; $display("FAIL bp_frame_count: got %0d, expected 2", frame_count); end
    endtask

    task automatic test_short_long();
        int es_n = 0, el_n = 0, eof_n = 0;
        cfg_width = 5'd8; cfg_height = 4'd3; tvalid = 1; tready = 1;
        for (int c = 0; c < 200; c++) begin
            sof_in = (c == 0);
            eol_in = at_final_pixel();
            if (m_ph == MP_PIX && m_line == 0 && m_pix == PPC) eol_in = 1;   // second beat of first line
            if (m_ph == MP_PIX && m_line == 1) eol_in = 0;                   // second line never ends properly
            tick();
            tests++;
            if (obs_vec() !== exp_vec) begin
                fails++;
                $display("FAIL short_long_cycle%0d: got %h, expected %h", c, obs_vec(), exp_vec);
            end
            es_n += int'(err_short); el_n += int'(err_long); eof_n += int'(eof_out);
            if (m_ph == MP_IDLE) break;
        end
        sof_in = 0; eol_in = 0;
        tests++; if (es_n != 1) begin fails++; $display("FAIL err_short_count: got %0d, expected 1", es_n); end
        tests++; if (el_n != 1) begin fails++; $display("FAIL err_long_count: got %0d, expected 1", el_n); end
        tests++; if (eof_n != 1) begin fails++; $display("FAIL short_long_eof: got %0d, expected 1", eof_n); end
    endtask

    task automatic test_early_sof();
        int ee_n = 0, sof_n = 0, eof_n = 0;
        bit fired = 0;
        logic [15:0] fc_before;
        fc_before = m_frames;
        cfg_width = 5'd8; cfg_height = 4'd3; tvalid = 1; tready = 1;
        for (int c = 0; c < 300; c++) begin
            bit inject;
            inject = !fired && (m_ph == MP_PIX) && (m_line == 1) && (m_pix == 2 * PPC);
            sof_in = (c == 0) || inject;
            eol_in = at_final_pixel();
            tick();
            tests++;
            if (obs_vec() !== exp_vec) begin
                fails++;
                $display("FAIL early_sof_cycle%0d: got %h, expected %h", c, obs_vec(), exp_vec);
            end
            if (inject) begin
                fired = 1;
                tests++;
                if ({err_early_sof, sof_out} !== 2'b11 || frame_count !== fc_before) begin
                    fails++;
                    $display("FAIL early_sof_resync: err=%b sof=%b fc=%0d, expected err=1 sof=1 fc=%0d",
                             err_early_sof, sof_out, frame_count, fc_before);
                end
            end
            ee_n += int'(err_early_sof); sof_n += int'(sof_out); eof_n += int'(eof_out);
            if (m_ph == MP_IDLE) break;
        end
        sof_in = 0; eol_in = 0;
        tests++; if (ee_n != 1) begin fails++; $display("FAIL early_sof_count: got %0d, expected 1", ee_n); end
        tests++; if (sof_n != 2) begin fails++; $display("FAIL early_sof_sof_count: got %0d, expected 2", sof_n); end
        tests++; if (eof_n != 1) begin fails++; $display("FAIL early_sof_eof: got %0d, expected 1", eof_n); end
        tests++;
        if (frame_count !== fc_before + 16'd1) begin
            fails++;
            $display("FAIL early_sof_frame_count: got %0d, expected %0d", frame_count, fc_before + 16'd1);
        end
    endtask

    task automatic test_config();
        int bad_w[4] = '{7, 8, 18, 16};
        int bad_h[4] = '{3, 0, 3, 9};
        int sol_n = 0, eof_n = 0;
        tvalid = 1; tready = 1;
        for (int k = 0; k < 4; k++) begin
            cfg_width = WW'(bad_w[k]); cfg_height = HW'(bad_h[k]);
            sof_in = 1;
            tick();
            tests++;
            if (obs_vec() !== exp_vec || err_cfg !== 1'b1 || sof_out !== 1'b0) begin
                fails++;
                $display("FAIL cfg_reject_%0dx%0d: got %h, expected %h with err_cfg=1", bad_w[k], bad_h[k], obs_vec(), exp_vec);
            end
            sof_in = 0;
            tick();
            tests++;
            if (obs_vec() !== exp_vec || sol_out !== 1'b0 || err_cfg !== 1'b0) begin
                fails++;
                $display("FAIL cfg_idle_%0dx%0d: got %h, expected %h", bad_w[k], bad_h[k], obs_vec(), exp_vec);
            end
        end
        // Largest legal frame.
        cfg_width = 5'd16; cfg_height = 4'd8;
        for (int c = 0; c < 300; c++) begin
            sof_in = (c == 0);
            eol_in = at_final_pixel();
            tick();
            tests++;
            if (obs_vec() !== exp_vec) begin
                fails++;
                $display("FAIL cfg_max_cycle%0d: got %h, expected %h", c, obs_vec(), exp_vec);
            end
            sol_n += int'(sol_out); eof_n += int'(eof_out);
            if (m_ph == MP_IDLE) break;
        end
        sof_in = 0; eol_in = 0;
        tests++; if (sol_n != 8) begin fails++; $display("FAIL cfg_max_sol_count: got %0d, expected 8", sol_n); end
        tests++; if (eof_n != 1) begin fails++; $display("FAIL cfg_max_eof_count: got %0d, expected 1", eof_n); end
    endtask

    task automatic test_reset_wrap();
        cfg_width = 5'd8; cfg_height = 4'd3; tvalid = 1; tready = 1;
        sof_in = 1; tick(); sof_in = 0;
        for (int c = 0; c < 4; c++) tick();          // SOF, then into the first line
        areset = 1;
        tick();
        tests++;
        if (obs_vec() !== 24'h0) begin
            fails++;
            $display("FAIL reset_mid_frame: got %h, expected %h", obs_vec(), 24'h0);
        end
        areset = 0;
        for (int c = 0; c < 5; c++) begin             // no sof_in: must stay quiet
            eol_in = 1'($urandom_range(0, 1));
            tick();
            tests++;
            if (obs_vec() !== exp_vec || sol_out !== 1'b0) begin
                fails++;
                $display("FAIL reset_no_resume%0d: got %h, expected %h", c, obs_vec(), exp_vec);
            end
        end
        eol_in = 0;
        force dut.frame_count_q = 16'hFFFF;
        m_frames = 16'hFFFF;
        tick();
        release dut.frame_count_q;
        tests++;
        if (frame_count !== 16'hFFFF) begin
            fails++;
            $display("FAIL preload: got %h, expected ffff", frame_count);
        end
        cfg_width = 5'd2; cfg_height = 4'd1;
        for (int c = 0; c < 50; c++) begin
            sof_in = (c == 0);
            eol_in = at_final_pixel();
            tick();
            tests++;
            if (obs_vec() !== exp_vec) begin
                fails++;
                $display("FAIL wrap_cycle%0d: got %h, expected %h", c, obs_vec(), exp_vec);
            end
            if (m_ph == MP_IDLE) break;
        end
        sof_in = 0; eol_in = 0;
        tests++;
        if (frame_count !== 16'h0000) begin
            fails++;
            $display("FAIL frame_count_wrap: got %h, expected 0000", frame_count);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            areset     = ($urandom_range(0, 299) == 0);
            tvalid     = ($urandom_range(0, 3) != 0);
            tready     = ($urandom_range(0, 3) != 0);
            sof_in     = (m_ph == MP_IDLE) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
            eol_in     = ($urandom_range(0, 9) == 0) ? 1'($urandom_range(0, 1)) : at_final_pixel();
            cfg_width  = WW'(PPC * $urandom_range(1, W_MAX / PPC));
            cfg_height = HW'($urandom_range(1, H_MAX));
            tick();
            tests++;
            if (obs_vec() !== exp_vec) begin
                fails++;
                $display("FAIL random_cycle%0d: got %h, expected %h", c, obs_vec(), exp_vec);
            end
        end
        areset = 0; sof_in = 0; eol_in = 0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_short_long();
        test_early_sof();
        test_config();
        test_reset_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
